// File: rtl/std_aes_optimized.sv
// std_aes_optimized: AES-128 encryption controller for a compute-in-memory macro.
// The CIM holds the expanded round keys and the S-box. This block holds the cipher state,
// streams it out for AddRoundKey, issues S-box lookups, and does ShiftRows/MixColumns itself.
module std_aes_optimized (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         EN,
  input  logic [127:0] Din,
  input  logic         KDrdy,
  input  logic [7:0]   RIO_00,
  input  logic [7:0]   RIO_01,
  input  logic [7:0]   RIO_02,
  input  logic [7:0]   RIO_03,
  input  logic [7:0]   RIO_04,
  input  logic [7:0]   RIO_05,
  input  logic [7:0]   RIO_06,
  input  logic [7:0]   RIO_07,
  input  logic [7:0]   RIO_08,
  input  logic [7:0]   RIO_09,
  input  logic [7:0]   RIO_10,
  input  logic [7:0]   RIO_11,
  input  logic [7:0]   RIO_12,
  input  logic [7:0]   RIO_13,
  input  logic [7:0]   RIO_14,
  input  logic [7:0]   RIO_15,
  output logic [127:0] Dout,
  output logic         Kvld,
  output logic         Dvld,
  output logic         BSY,
  output logic [2:0]   DEMUX_ADD_00,
  output logic [2:0]   DEMUX_ADD_01,
  output logic [2:0]   DEMUX_ADD_02,
  output logic [2:0]   DEMUX_ADD_03,
  output logic [2:0]   DEMUX_ADD_04,
  output logic [2:0]   DEMUX_ADD_05,
  output logic [2:0]   DEMUX_ADD_06,
  output logic [2:0]   DEMUX_ADD_07,
  output logic [2:0]   DEMUX_ADD_08,
  output logic [2:0]   DEMUX_ADD_09,
  output logic [2:0]   DEMUX_ADD_10,
  output logic [2:0]   DEMUX_ADD_11,
  output logic [2:0]   DEMUX_ADD_12,
  output logic [2:0]   DEMUX_ADD_13,
  output logic [2:0]   DEMUX_ADD_14,
  output logic [2:0]   DEMUX_ADD_15,
  output logic [5:0]   RWL_DEC_ADD_00,
  output logic [5:0]   RWL_DEC_ADD_01,
  output logic [5:0]   RWL_DEC_ADD_02,
  output logic [5:0]   RWL_DEC_ADD_03,
  output logic [5:0]   RWL_DEC_ADD_04,
  output logic [5:0]   RWL_DEC_ADD_05,
  output logic [5:0]   RWL_DEC_ADD_06,
  output logic [5:0]   RWL_DEC_ADD_07,
  output logic [5:0]   RWL_DEC_ADD_08,
  output logic [5:0]   RWL_DEC_ADD_09,
  output logic [5:0]   RWL_DEC_ADD_10,
  output logic [5:0]   RWL_DEC_ADD_11,
  output logic [5:0]   RWL_DEC_ADD_12,
  output logic [5:0]   RWL_DEC_ADD_13,
  output logic [5:0]   RWL_DEC_ADD_14,
  output logic [5:0]   RWL_DEC_ADD_15,
  output logic [15:0]  IN
);

  localparam logic [3:0] LastRound = 4'd10;

  typedef enum logic [2:0] {StIdle, StArk, StCapt, StSbox, StLatch} state_e;

  state_e       st_q;
  logic [2:0]   cnt_q;
  logic [3:0]   rnd_q;
  logic [127:0] state_q;
  logic [2:0]   demux_q [16];
  logic [5:0]   rwl_q   [16];

  logic [7:0]   rio     [16];
  logic [7:0]   a_b     [16];
  logic [127:0] a_flat;
  logic [7:0]   sr      [16];
  logic [7:0]   mc      [16];
  logic [127:0] nxt_state;
  logic [15:0]  in_nxt;

  assign rio = '{RIO_00, RIO_01, RIO_02, RIO_03, RIO_04, RIO_05, RIO_06, RIO_07,
                 RIO_08, RIO_09, RIO_10, RIO_11, RIO_12, RIO_13, RIO_14, RIO_15};

  assign DEMUX_ADD_00 = demux_q[0];
  assign DEMUX_ADD_01 = demux_q[1];
  assign DEMUX_ADD_02 = demux_q[2];
  assign DEMUX_ADD_03 = demux_q[3];
  assign DEMUX_ADD_04 = demux_q[4];
  assign DEMUX_ADD_05 = demux_q[5];
  assign DEMUX_ADD_06 = demux_q[6];
  assign DEMUX_ADD_07 = demux_q[7];
  assign DEMUX_ADD_08 = demux_q[8];
  assign DEMUX_ADD_09 = demux_q[9];
  assign DEMUX_ADD_10 = demux_q[10];
  assign DEMUX_ADD_11 = demux_q[11];
  assign DEMUX_ADD_12 = demux_q[12];
  assign DEMUX_ADD_13 = demux_q[13];
  assign DEMUX_ADD_14 = demux_q[14];
  assign DEMUX_ADD_15 = demux_q[15];

  assign RWL_DEC_ADD_00 = rwl_q[0];
  assign RWL_DEC_ADD_01 = rwl_q[1];
  assign RWL_DEC_ADD_02 = rwl_q[2];
  assign RWL_DEC_ADD_03 = rwl_q[3];
  assign RWL_DEC_ADD_04 = rwl_q[4];
  assign RWL_DEC_ADD_05 = rwl_q[5];
  assign RWL_DEC_ADD_06 = rwl_q[6];
  assign RWL_DEC_ADD_07 = rwl_q[7];
  assign RWL_DEC_ADD_08 = rwl_q[8];
  assign RWL_DEC_ADD_09 = rwl_q[9];
  assign RWL_DEC_ADD_10 = rwl_q[10];
  assign RWL_DEC_ADD_11 = rwl_q[11];
  assign RWL_DEC_ADD_12 = rwl_q[12];
  assign RWL_DEC_ADD_13 = rwl_q[13];
  assign RWL_DEC_ADD_14 = rwl_q[14];
  assign RWL_DEC_ADD_15 = rwl_q[15];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Undo the CIM's bit-transposed AddRoundKey readout into byte form
  always_comb begin
    for (int j = 0; j < 16; j++) a_b[j] = '0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) begin
        a_b[2*k][i]   = rio[2*i][7-k];
        a_b[2*k+1][i] = rio[2*i+1][7-k];
      end
    end
    a_flat = '0;
    for (int j = 0; j < 16; j++) a_flat[127-8*j -: 8] = a_b[j];
  end

  // ShiftRows on the S-box bytes, then MixColumns except in the last full round
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) sr[r+4*c] = rio[r+4*((c+r)%4)];
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    nxt_state = '0;
    for (int j = 0; j < 16; j++) begin
      nxt_state[127-8*j -: 8] = (rnd_q == 4'd9) ? sr[j] : mc[j];
    end
  end

  // Byte pair for the next ARK cycle
  always_comb begin
    in_nxt = '0;
    for (int c = 0; c < 8; c++) begin
      if (3'(c) == cnt_q + 3'd1) in_nxt = state_q[127-16*c -: 16];
    end
  end

  // Round sequencer with registered CIM-facing and host-facing outputs
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      st_q    <= StIdle;
      cnt_q   <= '0;
      rnd_q   <= '0;
      state_q <= '0;
      Dout    <= '0;
      Kvld    <= 1'b0;
      Dvld    <= 1'b0;
      BSY     <= 1'b0;
      IN      <= '0;
      for (int j = 0; j < 16; j++) begin
        demux_q[j] <= '0;
        rwl_q[j]   <= '0;
      end
    end else if (EN) begin
      Kvld <= 1'b0;
      Dvld <= 1'b0;
      unique case (st_q)
        StIdle: begin
          if (KDrdy) begin
            state_q <= Din;
            rnd_q   <= '0;
            cnt_q   <= '0;
            BSY     <= 1'b1;
            Kvld    <= 1'b1;
            IN      <= Din[127:112];
            st_q    <= StArk;
          end
        end
        StArk: begin
          if (cnt_q == 3'd7) begin
            cnt_q <= '0;
            IN    <= '0;
            st_q  <= StCapt;
          end else begin
            cnt_q <= cnt_q + 3'd1;
            IN    <= in_nxt;
          end
        end
        StCapt: begin
          if (rnd_q == LastRound) begin
            Dout  <= a_flat;
            Dvld  <= 1'b1;
            BSY   <= 1'b0;
            rnd_q <= '0;
            st_q  <= StIdle;
          end else begin
            for (int j = 0; j < 16; j++) begin
              demux_q[j] <= {1'b0, a_b[j][7:6]};
              rwl_q[j]   <= a_b[j][5:0];
            end
            st_q <= StSbox;
          end
        end
        StSbox: begin
          for (int j = 0; j < 16; j++) begin
            demux_q[j] <= '0;
            rwl_q[j]   <= '0;
          end
          st_q <= StLatch;
        end
        StLatch: begin
          state_q <= nxt_state;
          rnd_q   <= rnd_q + 4'd1;
          cnt_q   <= '0;
          IN      <= nxt_state[127:112];
          st_q    <= StArk;
        end
        default: st_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_std_aes_optimized.sv
// Self-checking bench for std_aes_optimized with a behavioural CIM (round keys + S-box).
module tb_std_aes_optimized;

  logic         CLK = 1'b0;
  logic         RSTn = 1'b0;
  logic         EN = 1'b1;
  logic         KDrdy = 1'b0;
  logic [127:0] Din = '0;
  logic [7:0]   rio [16];
  logic [127:0] Dout;
  logic         Kvld, Dvld, BSY;
  logic [2:0]   dmx [16];
  logic [5:0]   rwl [16];
  logic [15:0]  IN;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  std_aes_optimized dut (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .Din(Din), .KDrdy(KDrdy),
    .RIO_00(rio[0]), .RIO_01(rio[1]), .RIO_02(rio[2]), .RIO_03(rio[3]),
    .RIO_04(rio[4]), .RIO_05(rio[5]), .RIO_06(rio[6]), .RIO_07(rio[7]),
    .RIO_08(rio[8]), .RIO_09(rio[9]), .RIO_10(rio[10]), .RIO_11(rio[11]),
    .RIO_12(rio[12]), .RIO_13(rio[13]), .RIO_14(rio[14]), .RIO_15(rio[15]),
    .Dout(Dout), .Kvld(Kvld), .Dvld(Dvld), .BSY(BSY),
    .DEMUX_ADD_00(dmx[0]), .DEMUX_ADD_01(dmx[1]), .DEMUX_ADD_02(dmx[2]),
    .DEMUX_ADD_03(dmx[3]), .DEMUX_ADD_04(dmx[4]), .DEMUX_ADD_05(dmx[5]),
    .DEMUX_ADD_06(dmx[6]), .DEMUX_ADD_07(dmx[7]), .DEMUX_ADD_08(dmx[8]),
    .DEMUX_ADD_09(dmx[9]), .DEMUX_ADD_10(dmx[10]), .DEMUX_ADD_11(dmx[11]),
    .DEMUX_ADD_12(dmx[12]), .DEMUX_ADD_13(dmx[13]), .DEMUX_ADD_14(dmx[14]),
    .DEMUX_ADD_15(dmx[15]),
    .RWL_DEC_ADD_00(rwl[0]), .RWL_DEC_ADD_01(rwl[1]), .RWL_DEC_ADD_02(rwl[2]),
    .RWL_DEC_ADD_03(rwl[3]), .RWL_DEC_ADD_04(rwl[4]), .RWL_DEC_ADD_05(rwl[5]),
    .RWL_DEC_ADD_06(rwl[6]), .RWL_DEC_ADD_07(rwl[7]), .RWL_DEC_ADD_08(rwl[8]),
    .RWL_DEC_ADD_09(rwl[9]), .RWL_DEC_ADD_10(rwl[10]), .RWL_DEC_ADD_11(rwl[11]),
    .RWL_DEC_ADD_12(rwl[12]), .RWL_DEC_ADD_13(rwl[13]), .RWL_DEC_ADD_14(rwl[14]),
    .RWL_DEC_ADD_15(rwl[15]),
    .IN(IN)
  );

  // ---------------- behavioural CIM ----------------
  logic [7:0]   sbox [256];
  logic [127:0] rk   [11];
  logic         act = 1'b0;
  int           t = 0;
  int           ph, rn;
  logic [15:0]  ibuf [8];
  logic [8:0]   abuf [16];
  logic [7:0]   ab   [16];

  always_comb begin
    ph = (t < 110) ? (t % 11) : (t - 110);
    rn = (t < 110) ? (t / 11) : 10;
  end

  // Track the access sequence from the accepted start strobe on
  always @(posedge CLK) begin
    if (!RSTn) begin
      act <= 1'b0;
      t   <= 0;
    end else if (EN) begin
      if (!act) begin
        if (KDrdy) begin
          act <= 1'b1;
          t   <= 0;
        end
      end else begin
        if (ph < 8) ibuf[ph] <= IN;
        if (ph == 9) for (int j = 0; j < 16; j++) abuf[j] <= {dmx[j], rwl[j]};
        if (t == 118) act <= 1'b0;
        t <= t + 1;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < 16; j++) begin
      rio[j] = 8'h5a;
      ab[j]  = (j % 2 == 0) ? ibuf[j/2][15:8] : ibuf[j/2][7:0];
      ab[j]  = ab[j] ^ rk[rn][127-8*j -: 8];
    end
    if (act && ph == 8) begin
      for (int k = 0; k < 8; k++) begin
        for (int i = 0; i < 8; i++) begin
          rio[2*i][7-k]   = ab[2*k][i];
          rio[2*i+1][7-k] = ab[2*k+1][i];
        end
      end
    end else if (act && ph == 10 && rn < 10) begin
      for (int j = 0; j < 16; j++) rio[j] = sbox[abuf[j][7:0]];
    end
  end

  // ---------------- reference helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]}
              ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [127:0] act_v, input logic [127:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
    end
  endtask

  task automatic chk_zero(input string nm);
    logic any;
    any = 1'b0;
    for (int j = 0; j < 16; j++) any = any | (|dmx[j]) | (|rwl[j]);
    chk({nm, "_dout"}, Dout, 0);
    chk({nm, "_flags"}, {Kvld, Dvld, BSY}, 0);
    chk({nm, "_in"}, IN, 0);
    chk({nm, "_addr"}, any, 0);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] din;
    logic [127:0] exp;
    int           lat;
    int           gap_at;
    int           gap_len;
    int           inj_at;
    bit           probes;
  } vec_t;

  task automatic start_enc(input logic [127:0] din);
    Din   = din;
    KDrdy = 1'b1;
    @(posedge CLK); #1;
    KDrdy = 1'b0;
    Din   = ~din;
    chk("kvld_ack", Kvld, 1);
    chk("bsy_start", BSY, 1);
  endtask

  // Returns 1ns after the edge that raises Dvld (or after the cycle budget)
  task automatic wait_done(input vec_t v);
    int n;
    bit seen, bsy_bad;
    n = 0; seen = 0; bsy_bad = 0;
    while (!seen && n < 300) begin
      if (n == 1) chk("kvld_one_cycle", Kvld, 0);
      if (v.probes) begin
        if (n == 0) chk("in_c0", IN, 16'h0011);
        if (n == 7) chk("in_c7", IN, 16'heeff);
        if (n == 8) chk("in_capt_zero", IN, 0);
        if (n == 9) chk("sbox_addr_b0", {dmx[0], rwl[0]}, {3'b000, 6'h00});
        if (n == 9) chk("sbox_addr_b15", {dmx[15], rwl[15]}, {3'b011, 6'h30});
        if (n == 10) chk("addr_latch_zero", {dmx[15], rwl[15]}, 0);
      end
      if (n == v.gap_at) EN = 1'b0;
      if (n == v.gap_at + v.gap_len) EN = 1'b1;
      if (n == v.inj_at) KDrdy = 1'b1;
      if (n == v.inj_at + 1) begin
        KDrdy = 1'b0;
        chk("kvld_while_busy", Kvld, 0);
      end
      @(posedge CLK); #1;
      n++;
      if (Dvld) seen = 1;
      else if (!BSY) bsy_bad = 1;
    end
    chk("dvld_seen", seen, 1);
    chk("latency", n, v.lat);
    chk("dout", Dout, v.exp);
    chk("bsy_fall", BSY, 0);
    chk("bsy_held", bsy_bad, 0);
  endtask

  task automatic post_check(input vec_t v);
    @(posedge CLK); #1;
    chk("dvld_pulse", Dvld, 0);
    repeat (3) @(posedge CLK);
    #1;
    chk("dout_hold", Dout, v.exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [4];
    vec_t vc1;
    logic [127:0] k1, d1, e1, kz, ez;
    int n;
    bit dv_bad;

    k1 = 128'h000102030405060708090a0b0c0d0e0f;
    d1 = 128'h00112233445566778899aabbccddeeff;
    e1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    kz = 128'h0;
    ez = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    vecs[0] = '{key: k1, din: d1, exp: e1, lat: 119, gap_at: -10, gap_len: 0, inj_at: -10,
                probes: 1'b1};
    vecs[1] = '{key: kz, din: 128'h0, exp: ez, lat: 119, gap_at: -10, gap_len: 0, inj_at: -10,
                probes: 1'b0};
    vecs[2] = '{key: k1, din: d1, exp: e1, lat: 124, gap_at: 47, gap_len: 5, inj_at: -10,
                probes: 1'b0};
    vecs[3] = '{key: k1, din: d1, exp: e1, lat: 119, gap_at: -10, gap_len: 0, inj_at: 30,
                probes: 1'b0};
    vc1 = vecs[0];
    vc1.probes = 1'b0;

    build_sbox();
    expand(k1);

    RSTn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_zero("reset");
    RSTn = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 4; i++) begin
      expand(vecs[i].key);
      start_enc(vecs[i].din);
      wait_done(vecs[i]);
      post_check(vecs[i]);
    end

    // Back-to-back: a start strobe in the Dvld cycle must be accepted
    expand(k1);
    start_enc(d1);
    wait_done(vc1);
    start_enc(d1);
    wait_done(vc1);
    post_check(vc1);

    // Reset at E0+50 aborts the run with no Dvld; a fresh start then completes
    start_enc(d1);
    for (n = 0; n < 49; n++) begin
      @(posedge CLK); #1;
    end
    RSTn = 1'b0;
    @(posedge CLK); #1;
    chk_zero("abort");
    @(posedge CLK); #1;
    RSTn = 1'b1;
    dv_bad = 0;
    repeat (150) begin
      @(posedge CLK); #1;
      if (Dvld || BSY) dv_bad = 1;
    end
    chk("abort_no_dvld", dv_bad, 0);
    start_enc(d1);
    wait_done(vc1);
    post_check(vc1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/std_aes_optimized.md
# std_aes_optimized

AES-128 encryption controller for a compute-in-memory (CIM) macro that stores the expanded round keys and the S-box. The block keeps the 128-bit cipher state. It streams the state into the CIM for AddRoundKey, drives S-box lookup addresses, and applies ShiftRows and MixColumns locally. It sits between the host data path (Din/Dout) and the CIM array's row, demux and IO ports.

## Interface
- No parameters. Fixed AES-128, 10 rounds.
- CLK  in  1  single clock; all logic updates on the rising edge.
- RSTn  in  1  synchronous, active-low reset.
- EN  in  1  global enable. When low, all registers hold.
- Din  in  128  plaintext. Byte 0 = Din[127:120].
- KDrdy  in  1  start strobe. Latches Din and starts encryption when idle.
- RIO_00..RIO_15  in  8 each  CIM read outputs: the AddRoundKey result (bit-transposed) or S-box bytes.
- Dout  out  128  ciphertext; same byte order as Din.
- Kvld  out  1  one-cycle acknowledge of an accepted KDrdy.
- Dvld  out  1  one-cycle ciphertext-valid pulse.
- BSY  out  1  encryption in progress.
- DEMUX_ADD_00..15  out  3 each  S-box address high part for byte j.
- RWL_DEC_ADD_00..15  out  6 each  S-box address low part for byte j.
- IN  out  16  state bytes streamed to the CIM during AddRoundKey.

## Operation
- Idle:
  - Accepts KDrdy=1 when EN=1 and BSY=0.
  - On acceptance: loads state=Din, sets round r=0, sets BSY=1, pulses Kvld.
  - KDrdy while BSY=1 is ignored.
- Each round r=0..9 runs four states: ARK, CAPT, SBOX, LATCH.
- ARK (8 cycles, c=0..7):
  - IN = {state byte 2c, state byte 2c+1}.
  - The CIM XORs these bytes with round key r.
- CAPT (1 cycle): register the RIO ports as the ARK result A, using this bit mapping:
  - A byte 2k bit i = RIO_{2i}[7-k].
  - A byte 2k+1 bit i = RIO_{2i+1}[7-k].
  - k, i = 0..7; bit 0 = LSB.
- SBOX (1 cycle): for each byte j, drive DEMUX_ADD_j = {1'b0, A_j[7:6]} and RWL_DEC_ADD_j = A_j[5:0]. The CIM returns S(A_j) on RIO_j one cycle later.
- LATCH (1 cycle):
  - Register RIO_j as S_j.
  - Apply ShiftRows.
  - Apply MixColumns only when r<9.
  - Store the result as the new state; r increments.
- Final round (r=10): ARK with key 10 (8 cycles), then CAPT. A is written directly to Dout.
- Completion: on the edge after the final CAPT, Dvld=1 for one cycle and BSY falls to 0 in that same cycle.
- Dout holds its value until the next completion or reset.
- MixColumns is per column over GF(2^8) with polynomial 0x11B; xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0).
- IN and all address ports are registered. They read 0 outside ARK and SBOX respectively.

## Timing
- Reset (RSTn=0 at a rising edge):
  - Dout=0, Kvld=0, Dvld=0, BSY=0, IN=0, all DEMUX_ADD=0, all RWL_DEC_ADD=0.
  - FSM returns to idle and r=0.
  - Reset mid-operation aborts the encryption with no Dvld.
- Edge E0 samples an accepted KDrdy. In the following cycle: BSY=1, Kvld=1 (one cycle), ARK cycle 0 is active.
- Rounds 0..9 take 11 cycles each (8+1+1+1): 110 cycles.
- The final ARK+CAPT takes 9 cycles.
- Dvld and Dout become valid in the cycle starting at edge E0+119.
- EN=0 freezes the FSM, counters and outputs. Latency extends by the number of EN-low cycles.
- KDrdy in the Dvld cycle is accepted, since BSY=0 in that cycle.
- The CIM timing contract:
  - RIO is stable at the CAPT edge.
  - For the S-box read, the address is presented in SBOX and the data is sampled at the LATCH edge.

## Test plan
- FIPS-197 C.1:
  - Stimulus: behavioral CIM model with key 000102…0f; Din=00112233445566778899aabbccddeeff.
  - Response: Dout=69c4e0d86a7b0430d8cdb78070b4c55a with a one-cycle Dvld at E0+119; Kvld at E0+1; BSY high from E0+1 to E0+118.
- Zero key and zero Din -> Dout=66e94bd4ef8a2c3b884cfa59ca342b2e.
- Round-0 address check (C.1 vectors), SBOX cycle of round 0:
  - DEMUX_ADD_00=0, RWL_DEC_ADD_00=0x00.
  - DEMUX_ADD_15=3'b011, RWL_DEC_ADD_15=0x30 (byte 15 = ff^0f = f0).
- IN check: at ARK c=0, IN=0x0011; at c=7, IN=0xeeff.
- EN held low for 5 cycles mid-round 4 -> same ciphertext, Dvld at E0+124.
- Robustness:
  - A second KDrdy while BSY=1 -> no Kvld, result unchanged.
  - RSTn low at E0+50 -> all outputs 0, no Dvld.
  - A new KDrdy afterwards completes normally.
